// File: rtl/fht_unload_pkg.sv
// Shared definitions for the FHT result unloader: FSM state encoding and
// default widths taken over from the FHT core.
package fht_unload_pkg;

  localparam int D_BIT_DEF = 17;
  localparam int A_BIT_DEF = 6;
  localparam int O_BIT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fht_unload_conv.sv
// Narrows a D_BIT FHT word to the O_BIT stream width. FHT_UNLOAD_SAT_EN
// selects saturation; otherwise the word is arithmetically scaled down.
module fht_unload_conv #(
  parameter int D_BIT = 17,
  parameter int O_BIT = 16
) (
  input  logic signed [D_BIT-1:0] i_word,
  output logic signed [O_BIT-1:0] o_word
);

  generate
    if (O_BIT == D_BIT) begin : g_pass
      assign o_word = i_word;
    end else begin : g_narrow
`ifdef FHT_UNLOAD_SAT_EN
      // In range exactly when every bit above the O_BIT sign bit copies it.
      logic [D_BIT-O_BIT:0] w_top;
      assign w_top = i_word[D_BIT-1:O_BIT-1];
      always_comb begin
        if ((&w_top) || (~|w_top)) begin
          o_word = i_word[O_BIT-1:0];
        end else if (i_word[D_BIT-1]) begin
          o_word = {1'b1, {(O_BIT-1){1'b0}}};
        end else begin
          o_word = {1'b0, {(O_BIT-1){1'b1}}};
        end
      end
`else
      logic w_unusedLsbs;
      assign o_word       = i_word[D_BIT-1:D_BIT-O_BIT];
      assign w_unusedLsbs = ^i_word[D_BIT-O_BIT-1:0];
`endif
    end
  endgenerate

endmodule

// File: rtl/fht_unload.sv
// FHT result unloader: reads the four bank rows and streams the N points in
// index order on a valid/ready port. Narrowing mode set by FHT_UNLOAD_SAT_EN.
module fht_unload
  import fht_unload_pkg::*;
#(
  parameter int D_BIT = D_BIT_DEF,
  parameter int A_BIT = A_BIT_DEF,
  parameter int O_BIT = O_BIT_DEF
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iSTART_RD,
  input  logic                    iFHT_RDY,
  output logic [A_BIT-1:0]        oADDR_RD_0,
  output logic [A_BIT-1:0]        oADDR_RD_1,
  output logic [A_BIT-1:0]        oADDR_RD_2,
  output logic [A_BIT-1:0]        oADDR_RD_3,
  input  logic signed [D_BIT-1:0] iDATA_0,
  input  logic signed [D_BIT-1:0] iDATA_1,
  input  logic signed [D_BIT-1:0] iDATA_2,
  input  logic signed [D_BIT-1:0] iDATA_3,
  output logic signed [O_BIT-1:0] oDATA,
  output logic [A_BIT+1:0]        oINDEX,
  output logic                    oVALID,
  input  logic                    iREADY,
  output logic                    oLAST,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic                    oERR
);

  localparam int K_BIT = A_BIT + 2;
  localparam logic [A_BIT-1:0] ADDR_MAX = '1;
  localparam logic [K_BIT-1:0] K_LAST   = '1;

  state_t r_state, w_next;

  logic [A_BIT-1:0]        r_addr;
  logic [1:0]              r_rdPipe;
  logic signed [D_BIT-1:0] r_line [4];
  logic signed [D_BIT-1:0] r_pf   [4];
  logic signed [D_BIT-1:0] w_rd   [4];
  logic                    r_lineValid;
  logic                    r_pfFull;
  logic                    r_err;
  logic [K_BIT-1:0]        r_k;
  logic                    w_start;
  logic                    w_abort;
  logic                    w_accept;
  logic signed [D_BIT-1:0] w_word;

  assign w_rd[0] = iDATA_0;
  assign w_rd[1] = iDATA_1;
  assign w_rd[2] = iDATA_2;
  assign w_rd[3] = iDATA_3;

  assign w_start  = iSTART_RD & iFHT_RDY;
  assign w_abort  = ((r_state == S_FETCH) || (r_state == S_STREAM)) && !iFHT_RDY;
  assign w_accept = r_lineValid & iREADY;

  always_ff @(posedge iCLK) begin
    if (iRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    oBUSY  = 1'b1;
    oDONE  = 1'b0;
    case (r_state)
      S_IDLE: begin
        oBUSY = 1'b0;
        if (w_start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (!iFHT_RDY)        w_next = S_IDLE;
        else if (r_rdPipe[1]) w_next = S_STREAM;
      end
      S_STREAM: begin
        if (!iFHT_RDY)                        w_next = S_IDLE;
        else if (w_accept && (r_k == K_LAST)) w_next = S_DONE;
      end
      default: begin
        oDONE  = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  // r_rdPipe tracks an issued row: bit 0 while the RAM registers it, bit 1
  // while its data sits on iDATA_x and can be captured.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_addr      <= '0;
      r_rdPipe    <= '0;
      r_line      <= '{default: '0};
      r_pf        <= '{default: '0};
      r_lineValid <= 1'b0;
      r_pfFull    <= 1'b0;
      r_err       <= 1'b0;
      r_k         <= '0;
    end else begin
      r_err    <= w_abort;
      r_rdPipe <= {r_rdPipe[0], 1'b0};
      if (w_abort) begin
        r_rdPipe    <= '0;
        r_lineValid <= 1'b0;
        r_pfFull    <= 1'b0;
        r_k         <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_addr   <= '0;
              r_rdPipe <= 2'b01;
              r_k      <= '0;
            end
          end
          S_FETCH: begin
            if (r_rdPipe[1]) begin
              r_line      <= w_rd;
              r_lineValid <= 1'b1;
              if (r_addr != ADDR_MAX) begin
                r_addr   <= r_addr + 1'b1;
                r_rdPipe <= {r_rdPipe[0], 1'b1};
              end
            end
          end
          S_STREAM: begin
            if (r_rdPipe[1]) begin
              r_pf     <= w_rd;
              r_pfFull <= 1'b1;
            end
            if (w_accept) begin
              r_k <= r_k + 1'b1;
              if (r_k == K_LAST) begin
                r_lineValid <= 1'b0;
              end else if (r_k[1:0] == 2'd3) begin
                // The prefetched row always lands two beats before it is needed.
                r_line   <= r_pf;
                r_pfFull <= 1'b0;
                if (r_addr != ADDR_MAX) begin
                  r_addr   <= r_addr + 1'b1;
                  r_rdPipe <= {r_rdPipe[0], 1'b1};
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_word = r_line[r_k[1:0]];

  fht_unload_conv #(
    .D_BIT (D_BIT),
    .O_BIT (O_BIT)
  ) u_conv (
    .i_word (w_word),
    .o_word (oDATA)
  );

  assign oADDR_RD_0 = r_addr;
  assign oADDR_RD_1 = r_addr;
  assign oADDR_RD_2 = r_addr;
  assign oADDR_RD_3 = r_addr;
  assign oINDEX     = r_k;
  assign oVALID     = r_lineValid;
  assign oLAST      = r_lineValid && (r_k == K_LAST);
  assign oERR       = r_err;

endmodule

// File: tb/tb_fht_unload.sv
// Scoreboard bench for fht_unload: a bank RAM model feeds the DUT, expected
// beats are queued at stimulus time and a monitor pops them on each transfer.
module tb_fht_unload;

  localparam int N = 256;

  logic               iCLK = 1'b0;
  logic               iRESET;
  logic               iSTART_RD;
  logic               iFHT_RDY;
  logic [5:0]         oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic signed [16:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3;
  logic signed [15:0] oDATA;
  logic [7:0]         oINDEX;
  logic               oVALID;
  logic               iREADY;
  logic               oLAST;
  logic               oBUSY;
  logic               oDONE;
  logic               oERR;

  typedef struct {
    int idx;
    int data;
    int last;
  } beat_t;

  beat_t              sbQ[$];
  logic signed [16:0] mem [N];
  int                 nChecks = 0;
  int                 nErrors = 0;
  int                 cycle = 0;
  int                 lastXferCycle = -1;
  bit                 rdyRandom = 1'b0;

  fht_unload dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iSTART_RD  (iSTART_RD),
    .iFHT_RDY   (iFHT_RDY),
    .oADDR_RD_0 (oADDR_RD_0),
    .oADDR_RD_1 (oADDR_RD_1),
    .oADDR_RD_2 (oADDR_RD_2),
    .oADDR_RD_3 (oADDR_RD_3),
    .iDATA_0    (iDATA_0),
    .iDATA_1    (iDATA_1),
    .iDATA_2    (iDATA_2),
    .iDATA_3    (iDATA_3),
    .oDATA      (oDATA),
    .oINDEX     (oINDEX),
    .oVALID     (oVALID),
    .iREADY     (iREADY),
    .oLAST      (oLAST),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE),
    .oERR       (oERR)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cycle <= cycle + 1;

  // Bank RAMs with registered outputs; point k lives in bank k[1:0], row k[7:2].
  always @(posedge iCLK) begin
    iDATA_0 <= mem[int'({oADDR_RD_0, 2'd0})];
    iDATA_1 <= mem[int'({oADDR_RD_1, 2'd1})];
    iDATA_2 <= mem[int'({oADDR_RD_2, 2'd2})];
    iDATA_3 <= mem[int'({oADDR_RD_3, 2'd3})];
  end

  initial begin
    iREADY = 1'b1;
    forever begin
      @(posedge iCLK);
      #1;
      iREADY = rdyRandom ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Stored word for point k; pattern 1 plants hand-picked extremes at 8..15.
  function automatic int wordFor(input int k, input int pat);
    if (pat == 1) begin
      case (k)
        8:  return 40000;
        9:  return -40000;
        10: return 65535;
        11: return -65536;
        12: return 32767;
        13: return -32768;
        14: return -1;
        15: return 32768;
        default: ;
      endcase
    end
    return k;
  endfunction

  function automatic int expFor(input int k, input int pat);
    if (pat == 1 && k >= 8 && k < 16) begin
`ifdef FHT_UNLOAD_SAT_EN
      case (k)
        8:  return 32767;
        9:  return -32768;
        10: return 32767;
        11: return -32768;
        12: return 32767;
        13: return -32768;
        14: return -1;
        default: return 32767;
      endcase
`else
      case (k)
        8:  return 20000;
        9:  return -20000;
        10: return 32767;
        11: return -32768;
        12: return 16383;
        13: return -16384;
        14: return -1;
        default: return 16384;
      endcase
`endif
    end
`ifdef FHT_UNLOAD_SAT_EN
    return k;
`else
    return k / 2;
`endif
  endfunction

  task automatic pulseStart();
    @(negedge iCLK);
    iSTART_RD = 1'b1;
    @(negedge iCLK);
    iSTART_RD = 1'b0;
  endtask

  // Loads a frame, queues the first nExpect beats and requests the unload.
  task automatic applyStimulus(input int pat, input int nExpect);
    beat_t b;
    for (int k = 0; k < N; k++) mem[k] = 17'(wordFor(k, pat));
    for (int k = 0; k < nExpect; k++) begin
      b.idx  = k;
      b.data = expFor(k, pat);
      b.last = (k == N - 1) ? 1 : 0;
      sbQ.push_back(b);
    end
    pulseStart();
  endtask

  task automatic waitIndex(input string tag, input int k);
    int n;
    n = 0;
    while (!(oVALID && int'(oINDEX) == k) && n < 4000) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= 4000) checkOutput({tag, "_indexTimeout"}, int'(oINDEX), k);
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!oDONE && n < 5000) begin
      @(negedge iCLK);
      n++;
    end
    checkOutput({tag, "_doneSeen"}, int'(oDONE), 1);
    if (oDONE) begin
      checkOutput({tag, "_doneCycle"}, cycle, lastXferCycle);
      checkOutput({tag, "_sbEmpty"}, sbQ.size(), 0);
      @(negedge iCLK);
      checkOutput({tag, "_busyAfter"}, int'(oBUSY), 0);
      checkOutput({tag, "_donePulse"}, int'(oDONE), 0);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_valid"}, int'(oVALID), 0);
    checkOutput({tag, "_busy"},  int'(oBUSY), 0);
    checkOutput({tag, "_done"},  int'(oDONE), 0);
    checkOutput({tag, "_err"},   int'(oERR), 0);
    checkOutput({tag, "_last"},  int'(oLAST), 0);
    checkOutput({tag, "_index"}, int'(oINDEX), 0);
    checkOutput({tag, "_data"},  int'(oDATA), 0);
    checkOutput({tag, "_addr"},  int'(oADDR_RD_0), 0);
  endtask

  // Monitor: pops one expected beat per transfer and checks stall stability.
  initial begin
    beat_t b;
    bit    held;
    int    hIdx, hData, hLast;
    held = 1'b0;
    forever begin
      @(negedge iCLK);
      if (iRESET || !iFHT_RDY) begin
        held = 1'b0;
      end else if (held) begin
        checkOutput("holdValid", int'(oVALID), 1);
        checkOutput("holdIndex", int'(oINDEX), hIdx);
        checkOutput("holdData",  int'(oDATA), hData);
        checkOutput("holdLast",  int'(oLAST), hLast);
      end
      if (oVALID && iREADY) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedBeat", int'(oINDEX), -1);
        end else begin
          b = sbQ.pop_front();
          checkOutput("beatIndex", int'(oINDEX), b.idx);
          checkOutput("beatData",  int'(oDATA), b.data);
          checkOutput("beatLast",  int'(oLAST), b.last);
          if (oLAST) lastXferCycle = cycle + 1;
        end
      end
      held  = oVALID && !iREADY;
      hIdx  = int'(oINDEX);
      hData = int'(oDATA);
      hLast = int'(oLAST);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    iRESET    = 1'b1;
    iSTART_RD = 1'b0;
    iFHT_RDY  = 1'b0;
    for (int k = 0; k < N; k++) mem[k] = '0;
    repeat (3) @(negedge iCLK);
    checkIdleZero("reset");
    iRESET = 1'b0;

    $display("[TB] start gating with iFHT_RDY low");
    pulseStart();
    repeat (3) begin
      @(negedge iCLK);
      checkOutput("gate_busy",  int'(oBUSY), 0);
      checkOutput("gate_valid", int'(oVALID), 0);
    end

    $display("[TB] ramp frame, full rate, start injected mid-stream");
    iFHT_RDY = 1'b1;
    applyStimulus(0, N);
    checkOutput("lat_afterE0_valid", int'(oVALID), 0);
    checkOutput("lat_afterE0_busy",  int'(oBUSY), 1);
    checkOutput("lat_afterE0_addr",  int'(oADDR_RD_0), 0);
    @(negedge iCLK);
    checkOutput("lat_afterE1_valid", int'(oVALID), 0);
    @(negedge iCLK);
    checkOutput("lat_afterE2_valid", int'(oVALID), 1);
    checkOutput("lat_afterE2_index", int'(oINDEX), 0);
    waitIndex("ramp", 20);
    pulseStart();
    waitDone("ramp");

    $display("[TB] extreme-value frame under 30 percent ready");
    rdyRandom = 1'b1;
    applyStimulus(1, N);
    waitDone("sat");
    rdyRandom = 1'b0;

    $display("[TB] abort at beat 100");
    applyStimulus(0, 101);
    waitIndex("abort", 100);
    iFHT_RDY = 1'b0;
    @(negedge iCLK);
    checkOutput("abort_err",   int'(oERR), 1);
    checkOutput("abort_valid", int'(oVALID), 0);
    checkOutput("abort_busy",  int'(oBUSY), 0);
    checkOutput("abort_sbEmpty", sbQ.size(), 0);
    iFHT_RDY = 1'b1;
    repeat (3) begin
      @(negedge iCLK);
      checkOutput("abort_noDone", int'(oDONE), 0);
      checkOutput("abort_errPulse", int'(oERR), 0);
    end
    applyStimulus(0, N);
    waitDone("restart");

    $display("[TB] reset at beat 50");
    applyStimulus(0, 51);
    waitIndex("rst", 50);
    iRESET = 1'b1;
    @(negedge iCLK);
    checkIdleZero("midReset");
    checkOutput("midReset_sbEmpty", sbQ.size(), 0);
    iRESET = 1'b0;
    applyStimulus(0, N);
    waitDone("afterReset");

    repeat (2) @(negedge iCLK);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
